voice_sweeper: RTL and testbench
================================

# voice_sweeper

Parametrised polyphonic voice engine for the MIDI synth datapath. It holds NUM_VOICES voice records and allocates voices on note-on, with retrigger and round-robin stealing. Once per audio tick it sweeps all voices: phase is advanced via the external frequency ROM and a linear ADSR envelope is stepped. Each swept voice is streamed as one beat (phase, envelope, velocity) to the downstream sound generator.

## Interface
- NUM_VOICES, 16: voice count, power of 2, 2..64
- VI_W, $clog2(NUM_VOICES): voice index width
- PHASE_W, 19: phase accumulator width
- INC_W, 18: phase increment width
- ENV_W, 16: envelope width
- TICK_DIV, 2000: clk96 cycles per audio tick (48 kHz at 96 MHz); elaboration error unless 2*NUM_VOICES+3 < TICK_DIV
- clk96 in 1: system clock
- rst in 1: asynchronous, active-high reset
- cmd_valid in 1: event request
- cmd_ready out 1: event accepted when cmd_valid & cmd_ready
- cmd_on in 1: 1 = note-on, 0 = note-off
- cmd_note in 7: MIDI note
- cmd_vel in 7: velocity; note-on only
- cmd_chan in 4: MIDI channel
- pb_valid in 1: pitch-bend update strobe
- pb_chan in 4: bend channel
- pb_value in 5: bend, centre 16
- atk_rate, dec_rate, rel_rate in ENV_W: envelope steps per tick
- sus_level in ENV_W: sustain level
- inc_addr out 10: frequency ROM address
- inc_data in INC_W: ROM data, registered, 1-cycle latency
- beat_valid out 1: stream beat; no backpressure
- beat_voice out VI_W: voice index
- beat_phase out 10: phase[PHASE_W-1 -: 10]
- beat_env out ENV_W: envelope
- beat_vel out 7: velocity
- beat_last out 1: last voice of the sweep
- voice_freed out 1: one-cycle pulse when a release reaches 0
- freed_voice out VI_W: index of the freed voice

## Operation
- Per-voice state:
  - active flag
  - ADSR state: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE
  - note, channel, velocity
  - phase (PHASE_W)
  - env (ENV_W)
- Per-channel bend table: 16 x 5 bits, reset 16. A pb_valid write happens in any FSM state.
- Tick counter: 0..TICK_DIV-1, wraps. The tick is the cycle where count == TICK_DIV-1.
- FSM states: IDLE, LOOKUP, UPDATE.
  - IDLE: a tick moves to LOOKUP with vidx = 0.
  - LOOKUP: moves to UPDATE.
  - UPDATE: if vidx = NUM_VOICES-1, go to IDLE; else increment vidx and go to LOOKUP.
- cmd_ready = (state == IDLE) & ~tick & ~rst. A tick has priority over a command.
- Note-on allocation priority:
  1. Active voice with the same note and channel: retrigger. Go to ATTACK from the current env, keep phase, update velocity.
  2. Lowest-index IDLE voice: env = 0, phase = 0, ATTACK.
  3. Steal voice rr_ptr: env = 0, phase = 0, ATTACK. rr_ptr then increments mod NUM_VOICES. rr_ptr resets to 0.
- Note-off:
  - Every voice matching note and channel, in ATTACK, DECAY or SUSTAIN, goes to RELEASE.
  - No match: no effect.
- LOOKUP: inc_addr = {note,3'b000} + {5'b0,bend[chan]} - 16, mod 1024. Combinational from vidx.
- UPDATE: phase += inc_data, mod 2^PHASE_W. The envelope steps once, on unsigned values:
  - ATTACK: env + atk_rate ≥ 2^ENV_W-1 → env = max, DECAY. Otherwise add.
  - DECAY: env - dec_rate ≤ sus_level → env = sus_level, SUSTAIN. Otherwise subtract.
  - SUSTAIN: hold.
  - RELEASE: env ≤ rel_rate → env = 0, IDLE, voice_freed pulse. Otherwise subtract.
  - IDLE: phase and env are not updated.
- Every voice, idle or not, emits exactly one beat per sweep. The beat carries the post-update values.

## Timing
- Tick at cycle T: the LOOKUP for voice i is at T+1+2i and its UPDATE at T+2+2i.
- beat_* and voice_freed are registered. The beat for voice i is visible at T+3+2i.
- beat_last is high on the beat for voice NUM_VOICES-1.
- A command accepted at cycle C is applied to state at C+1. The next sweep sees it.
- Reset values:
  - all outputs 0
  - all voices IDLE, with phase, env and velocity 0
  - bend table 16; count 0; rr_ptr 0; FSM IDLE
- Reset mid-sweep aborts immediately. No further beats or voice_freed pulses are produced.

## Test plan
- Reset, then idle with TICK_DIV = 64 and NUM_VOICES = 4 → 4 beats per tick, each 2 cycles apart, env 0, beat_last on voice 3. cmd_ready = 0 on tick cycles.
- Note-on 60/ch0/vel 100 with atk_rate = 0x4000 → voice 0 env is 0x4000, 0x8000, 0xC000, then 0xFFFF and DECAY. inc_addr = 480.
- Set pb_value = 20 on ch0 → inc_addr = 484 at the next LOOKUP of voice 0.
- Note-off 60/ch0 with rel_rate = 0x8000 and env 0x9000 → env is 0x1000, then 0. voice_freed pulses with freed_voice = 0.
- Five note-ons on 4 voices → voices 0-3 are allocated, then the fifth steals voice 0 (env = 0, phase = 0). A sixth note-on steals voice 1.
- Repeat note-on 60/ch0 while it sounds → no new voice. Velocity updates and the state is ATTACK.
- Assert rst in the middle of a sweep → beats stop, all outputs are 0, and the first beat after release is at T+3 of the next tick.

Source files
------------

// File: rtl/voice_sweeper.sv
// Polyphonic voice engine: allocates voices on note events and, once per audio tick,
// sweeps every voice (phase advance via external ROM, linear ADSR) into a beat stream.
module voice_sweeper #(
  parameter int NUM_VOICES = 16,
  parameter int VI_W       = $clog2(NUM_VOICES),
  parameter int PHASE_W    = 19,
  parameter int INC_W      = 18,
  parameter int ENV_W      = 16,
  parameter int TICK_DIV   = 2000
) (
  input  logic             clk96,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_on,
  input  logic [6:0]       cmd_note,
  input  logic [6:0]       cmd_vel,
  input  logic [3:0]       cmd_chan,
  input  logic             pb_valid,
  input  logic [3:0]       pb_chan,
  input  logic [4:0]       pb_value,
  input  logic [ENV_W-1:0] atk_rate,
  input  logic [ENV_W-1:0] dec_rate,
  input  logic [ENV_W-1:0] rel_rate,
  input  logic [ENV_W-1:0] sus_level,
  output logic [9:0]       inc_addr,
  input  logic [INC_W-1:0] inc_data,
  output logic             beat_valid,
  output logic [VI_W-1:0]  beat_voice,
  output logic [9:0]       beat_phase,
  output logic [ENV_W-1:0] beat_env,
  output logic [6:0]       beat_vel,
  output logic             beat_last,
  output logic             voice_freed,
  output logic [VI_W-1:0]  freed_voice
);
  // state    | meaning
  // S_IDLE   | waiting for tick, commands accepted
  // S_LOOKUP | inc_addr presented for voice vidx
  // S_UPDATE | ROM data back; phase/envelope of vidx stepped, beat registered
  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE} state_t;
  typedef enum logic [2:0] {A_IDLE, A_ATTACK, A_DECAY, A_SUSTAIN, A_RELEASE} adsr_t;

  localparam int CNT_W = $clog2(TICK_DIV);

  if (2 * NUM_VOICES + 3 >= TICK_DIV) begin : g_bad_tick_div
    $error("voice_sweeper: TICK_DIV too small for a full sweep");
  end
  if ((NUM_VOICES < 2) || (NUM_VOICES > 64) || ((NUM_VOICES & (NUM_VOICES - 1)) != 0)) begin : g_bad_voices
    $error("voice_sweeper: NUM_VOICES must be a power of 2 in 2..64");
  end

  state_t               state, state_nxt;
  logic [VI_W-1:0]      vidx, vidx_nxt;
  logic [CNT_W-1:0]     count;
  logic                 tick;
  logic [VI_W-1:0]      rr_ptr;

  adsr_t                adsr  [NUM_VOICES];
  logic [6:0]           note  [NUM_VOICES];
  logic [6:0]           vel   [NUM_VOICES];
  logic [3:0]           chan  [NUM_VOICES];
  logic [PHASE_W-1:0]   phase [NUM_VOICES];
  logic [ENV_W-1:0]     env   [NUM_VOICES];
  logic [4:0]           bend  [16];

  logic                 cmd_fire;
  logic                 hit, free_found;
  logic [VI_W-1:0]      hit_idx, free_idx, alloc_idx;

  logic [ENV_W-1:0]     cur_env, env_nxt;
  logic [ENV_W:0]       att_sum, dec_diff;
  adsr_t                adsr_nxt;
  logic                 freed_nxt;
  logic [PHASE_W-1:0]   phase_nxt;

  assign tick      = (count == CNT_W'(TICK_DIV - 1));
  assign cmd_ready = (state == S_IDLE) & ~tick & ~rst;
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign inc_addr  = (state == S_LOOKUP) ?
                     ({note[vidx], 3'b000} + {5'b0, bend[chan[vidx]]} - 10'd16) : 10'd0;

  always_ff @(posedge clk96 or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      vidx  <= '0;
    end else begin
      state <= state_nxt;
      vidx  <= vidx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    vidx_nxt  = vidx;
    case (state)
      S_IDLE: if (tick) begin
        state_nxt = S_LOOKUP;
        vidx_nxt  = '0;
      end
      S_LOOKUP: state_nxt = S_UPDATE;
      S_UPDATE: if (vidx == VI_W'(NUM_VOICES - 1)) begin
        state_nxt = S_IDLE;
      end else begin
        state_nxt = S_LOOKUP;
        vidx_nxt  = vidx + VI_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if ((adsr[i] != A_IDLE) && (note[i] == cmd_note) && (chan[i] == cmd_chan)) begin
        hit     = 1'b1;
        hit_idx = VI_W'(i);
      end
      if (adsr[i] == A_IDLE) begin
        free_found = 1'b1;
        free_idx   = VI_W'(i);
      end
    end
    alloc_idx = free_found ? free_idx : rr_ptr;
  end

  // Decay underflow is treated as reaching the sustain level.
  always_comb begin
    cur_env   = env[vidx];
    env_nxt   = cur_env;
    adsr_nxt  = adsr[vidx];
    freed_nxt = 1'b0;
    att_sum   = {1'b0, cur_env} + {1'b0, atk_rate};
    dec_diff  = {1'b0, cur_env} - {1'b0, dec_rate};
    phase_nxt = phase[vidx];
    if (adsr[vidx] != A_IDLE) phase_nxt = phase[vidx] + PHASE_W'(inc_data);
    case (adsr[vidx])
      A_ATTACK:
        if (att_sum >= {1'b0, {ENV_W{1'b1}}}) begin
          env_nxt  = '1;
          adsr_nxt = A_DECAY;
        end else begin
          env_nxt = att_sum[ENV_W-1:0];
        end
      A_DECAY:
        if (dec_diff[ENV_W] || (dec_diff[ENV_W-1:0] <= sus_level)) begin
          env_nxt  = sus_level;
          adsr_nxt = A_SUSTAIN;
        end else begin
          env_nxt = dec_diff[ENV_W-1:0];
        end
      A_RELEASE:
        if (cur_env <= rel_rate) begin
          env_nxt   = '0;
          adsr_nxt  = A_IDLE;
          freed_nxt = 1'b1;
        end else begin
          env_nxt = cur_env - rel_rate;
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk96 or posedge rst) begin
    if (rst) begin
      count       <= '0;
      rr_ptr      <= '0;
      beat_valid  <= 1'b0;
      beat_voice  <= '0;
      beat_phase  <= '0;
      beat_env    <= '0;
      beat_vel    <= '0;
      beat_last   <= 1'b0;
      voice_freed <= 1'b0;
      freed_voice <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        adsr[i]  <= A_IDLE;
        note[i]  <= '0;
        vel[i]   <= '0;
        chan[i]  <= '0;
        phase[i] <= '0;
        env[i]   <= '0;
      end
      for (int c = 0; c < 16; c++) bend[c] <= 5'd16;
    end else begin
      count       <= tick ? '0 : count + CNT_W'(1);
      beat_valid  <= 1'b0;
      voice_freed <= 1'b0;
      if (pb_valid) bend[pb_chan] <= pb_value;
      if (cmd_fire) begin
        if (cmd_on && hit) begin
          adsr[hit_idx] <= A_ATTACK;
          vel[hit_idx]  <= cmd_vel;
        end else if (cmd_on) begin
          adsr[alloc_idx]  <= A_ATTACK;
          note[alloc_idx]  <= cmd_note;
          chan[alloc_idx]  <= cmd_chan;
          vel[alloc_idx]   <= cmd_vel;
          phase[alloc_idx] <= '0;
          env[alloc_idx]   <= '0;
          if (!free_found) rr_ptr <= rr_ptr + VI_W'(1);
        end else begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if ((adsr[i] inside {A_ATTACK, A_DECAY, A_SUSTAIN}) &&
                (note[i] == cmd_note) && (chan[i] == cmd_chan))
              adsr[i] <= A_RELEASE;
          end
        end
      end
      if (state == S_UPDATE) begin
        adsr[vidx]  <= adsr_nxt;
        env[vidx]   <= env_nxt;
        phase[vidx] <= phase_nxt;
        beat_valid  <= 1'b1;
        beat_voice  <= vidx;
        beat_phase  <= phase_nxt[PHASE_W-1 -: 10];
        beat_env    <= env_nxt;
        beat_vel    <= vel[vidx];
        beat_last   <= (vidx == VI_W'(NUM_VOICES - 1));
        voice_freed <= freed_nxt;
        if (freed_nxt) freed_voice <= vidx;
      end
    end
  end
endmodule

// File: tb/tb_voice_sweeper.sv
// Scoreboard bench for voice_sweeper: a behavioural voice model predicts every beat of
// every sweep; beats are popped and compared as the DUT emits them.
module tb_voice_sweeper;
  localparam int NV = 4;
  localparam int VW = 2;
  localparam int TD = 64;
  localparam int M_IDLE = 0, M_ATT = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;

  logic        clk96 = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_on;
  logic [6:0]  cmd_note, cmd_vel;
  logic [3:0]  cmd_chan;
  logic        pb_valid;
  logic [3:0]  pb_chan;
  logic [4:0]  pb_value;
  logic [15:0] atk_rate, dec_rate, rel_rate, sus_level;
  logic [9:0]  inc_addr;
  logic [17:0] inc_data;
  logic        beat_valid, beat_last, voice_freed;
  logic [VW-1:0] beat_voice, freed_voice;
  logic [9:0]  beat_phase;
  logic [15:0] beat_env;
  logic [6:0]  beat_vel;

  voice_sweeper #(.NUM_VOICES(NV), .TICK_DIV(TD)) dut (
    .clk96(clk96), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_on(cmd_on), .cmd_note(cmd_note), .cmd_vel(cmd_vel), .cmd_chan(cmd_chan),
    .pb_valid(pb_valid), .pb_chan(pb_chan), .pb_value(pb_value),
    .atk_rate(atk_rate), .dec_rate(dec_rate), .rel_rate(rel_rate), .sus_level(sus_level),
    .inc_addr(inc_addr), .inc_data(inc_data), .beat_valid(beat_valid),
    .beat_voice(beat_voice), .beat_phase(beat_phase), .beat_env(beat_env),
    .beat_vel(beat_vel), .beat_last(beat_last), .voice_freed(voice_freed),
    .freed_voice(freed_voice)
  );

  always #5 clk96 = ~clk96;

  // Frequency ROM stand-in: increment = address << 8, one cycle latency.
  always @(posedge clk96) inc_data <= {inc_addr, 8'h00};

  int tb_cnt;
  always @(posedge clk96 or posedge rst) begin
    if (rst) tb_cnt <= 0;
    else     tb_cnt <= (tb_cnt == TD - 1) ? 0 : tb_cnt + 1;
  end

  typedef struct {
    int voice; int phase; int env; int vel; bit last; bit freed; int addr;
  } exp_t;
  exp_t exp_q[$];

  int m_st[NV], m_note[NV], m_chan[NV], m_vel[NV], m_phase[NV], m_env[NV];
  int m_bend[16];
  int m_rr;
  int obs_env[NV], obs_vel[NV], obs_addr[NV], obs_phase[NV];
  int obs_freed;
  int total = 0;
  int bad = 0;

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_st[i] = M_IDLE; m_note[i] = 0; m_chan[i] = 0; m_vel[i] = 0;
      m_phase[i] = 0; m_env[i] = 0;
    end
    for (int c = 0; c < 16; c++) m_bend[c] = 16;
    m_rr = 0;
    exp_q.delete();
  endtask

  task automatic model_cmd(input bit on, input int note, input int vel, input int chan);
    int tgt;
    tgt = -1;
    if (on) begin
      for (int i = 0; i < NV; i++)
        if (tgt < 0 && m_st[i] != M_IDLE && m_note[i] == note && m_chan[i] == chan) tgt = i;
      if (tgt >= 0) begin
        m_st[tgt] = M_ATT; m_vel[tgt] = vel;
      end else begin
        for (int i = 0; i < NV; i++) if (tgt < 0 && m_st[i] == M_IDLE) tgt = i;
        if (tgt < 0) begin
          tgt = m_rr;
          m_rr = (m_rr + 1) % NV;
        end
        m_st[tgt] = M_ATT; m_note[tgt] = note; m_chan[tgt] = chan; m_vel[tgt] = vel;
        m_phase[tgt] = 0; m_env[tgt] = 0;
      end
    end else begin
      for (int i = 0; i < NV; i++)
        if (m_note[i] == note && m_chan[i] == chan &&
            (m_st[i] == M_ATT || m_st[i] == M_DEC || m_st[i] == M_SUS)) m_st[i] = M_REL;
    end
  endtask

  task automatic model_sweep();
    exp_t e;
    for (int i = 0; i < NV; i++) begin
      e.addr  = (m_note[i] * 8 + m_bend[m_chan[i]] + 1024 - 16) % 1024;
      e.freed = 1'b0;
      if (m_st[i] != M_IDLE) m_phase[i] = (m_phase[i] + e.addr * 256) % (1 << 19);
      case (m_st[i])
        M_ATT: if (m_env[i] + int'(atk_rate) >= 65535) begin
                 m_env[i] = 65535; m_st[i] = M_DEC;
               end else m_env[i] = m_env[i] + int'(atk_rate);
        M_DEC: if (m_env[i] - int'(dec_rate) <= int'(sus_level)) begin
                 m_env[i] = int'(sus_level); m_st[i] = M_SUS;
               end else m_env[i] = m_env[i] - int'(dec_rate);
        M_REL: if (m_env[i] <= int'(rel_rate)) begin
                 m_env[i] = 0; m_st[i] = M_IDLE; e.freed = 1'b1;
               end else m_env[i] = m_env[i] - int'(rel_rate);
        default: ;
      endcase
      e.voice = i; e.phase = m_phase[i] >> 9; e.env = m_env[i]; e.vel = m_vel[i];
      e.last = (i == NV - 1);
      exp_q.push_back(e);
    end
  endtask

  // Waits for the next tick, then checks every cycle of the sweep window.
  // abort_at > 0 asserts reset at that cycle offset after the tick.
  task automatic run_tick(input int abort_at);
    int guard;
    exp_t e;
    guard = 0;
    obs_freed = -1;
    @(negedge clk96);
    while (tb_cnt != TD - 1) begin
      total++;
      if (beat_valid !== 1'b0 || voice_freed !== 1'b0) begin
        bad++; $display("FAIL idle_beat: got valid=%b freed=%b want 0", beat_valid, voice_freed);
      end
      total++;
      if (cmd_ready !== 1'b1) begin
        bad++; $display("FAIL ready_idle: got %b want 1", cmd_ready);
      end
      guard++;
      if (guard > 3 * TD) begin
        total++; bad++; $display("FAIL tick_timeout: got no tick want tick within %0d", 3 * TD);
        return;
      end
      @(negedge clk96);
    end
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++; $display("FAIL ready_tick: got %b want 0", cmd_ready);
    end
    model_sweep();
    for (int k = 1; k <= 2 * NV + 4; k++) begin
      @(negedge clk96);
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        total++;
        if ({beat_valid, beat_voice, beat_phase, beat_env, beat_vel, beat_last,
             voice_freed, freed_voice, cmd_ready, inc_addr} !== '0) begin
          bad++; $display("FAIL reset_mid_outs: got valid=%b env=%h freed=%b ready=%b addr=%0d want all 0",
                          beat_valid, beat_env, voice_freed, cmd_ready, inc_addr);
        end
        repeat (3) begin
          @(negedge clk96);
          total++;
          if (beat_valid !== 1'b0 || voice_freed !== 1'b0) begin
            bad++; $display("FAIL reset_hold_beat: got valid=%b freed=%b want 0", beat_valid, voice_freed);
          end
        end
        rst = 1'b0;
        model_reset();
        return;
      end
      if (k % 2 == 1 && k >= 3 && (k - 3) / 2 < NV) begin
        e = exp_q.pop_front();
        total++;
        if (beat_valid !== 1'b1) begin
          bad++; $display("FAIL beat_missing v%0d: got valid=%b want 1", e.voice, beat_valid);
        end else begin
          obs_env[e.voice] = int'(beat_env); obs_vel[e.voice] = int'(beat_vel);
          obs_phase[e.voice] = int'(beat_phase);
          if (voice_freed === 1'b1) obs_freed = int'(freed_voice);
          total++;
          if (beat_voice !== VW'(e.voice) || beat_last !== e.last) begin
            bad++; $display("FAIL beat_idx: got voice=%0d last=%b want voice=%0d last=%b",
                            beat_voice, beat_last, e.voice, e.last);
          end
          total++;
          if (beat_env !== 16'(e.env)) begin
            bad++; $display("FAIL beat_env v%0d: got %h want %h", e.voice, beat_env, 16'(e.env));
          end
          total++;
          if (beat_phase !== 10'(e.phase)) begin
            bad++; $display("FAIL beat_phase v%0d: got %0d want %0d", e.voice, beat_phase, e.phase);
          end
          total++;
          if (beat_vel !== 7'(e.vel)) begin
            bad++; $display("FAIL beat_vel v%0d: got %0d want %0d", e.voice, beat_vel, e.vel);
          end
          total++;
          if (voice_freed !== e.freed || (e.freed && freed_voice !== VW'(e.voice))) begin
            bad++; $display("FAIL freed v%0d: got pulse=%b idx=%0d want pulse=%b", e.voice,
                            voice_freed, freed_voice, e.freed);
          end
        end
      end else begin
        total++;
        if (beat_valid !== 1'b0 || voice_freed !== 1'b0) begin
          bad++; $display("FAIL beat_timing k=%0d: got valid=%b freed=%b want 0", k, beat_valid, voice_freed);
        end
      end
      if (k % 2 == 1 && (k - 1) / 2 < NV) begin
        obs_addr[(k - 1) / 2] = int'(inc_addr);
        total++;
        if (exp_q.size() == 0 || inc_addr !== 10'(exp_q[0].addr)) begin
          bad++; $display("FAIL inc_addr k=%0d: got %0d want %0d", k, inc_addr,
                          exp_q.size() ? exp_q[0].addr : -1);
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL beats_left: got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic do_cmd(input bit on, input int note, input int vel, input int chan);
    int guard;
    guard = 0;
    @(negedge clk96);
    while (tb_cnt < 2 * NV + 6 || tb_cnt > TD - 4) begin
      guard++;
      if (guard > 2 * TD) begin
        total++; bad++; $display("FAIL cmd_window: got no window want one");
        return;
      end
      @(negedge clk96);
    end
    cmd_valid = 1'b1; cmd_on = on; cmd_note = 7'(note); cmd_vel = 7'(vel); cmd_chan = 4'(chan);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL cmd_ready: got %b want 1", cmd_ready);
    end
    model_cmd(on, note, vel, chan);
    @(negedge clk96);
    cmd_valid = 1'b0;
  endtask

  task automatic do_pb(input int chan, input int value);
    @(negedge clk96);
    pb_valid = 1'b1; pb_chan = 4'(chan); pb_value = 5'(value);
    m_bend[chan] = value;
    @(negedge clk96);
    pb_valid = 1'b0;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++; $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic test_reset();
    @(negedge clk96);
    total++;
    if ({beat_valid, beat_voice, beat_phase, beat_env, beat_vel, beat_last,
         voice_freed, freed_voice, cmd_ready, inc_addr} !== '0) begin
      bad++; $display("FAIL reset_outs: got valid=%b env=%h ready=%b addr=%0d want all 0",
                      beat_valid, beat_env, cmd_ready, inc_addr);
    end
    rst = 1'b0;
    run_tick(0);
    run_tick(0);
  endtask

  task automatic test_attack();
    int want[4] = '{32'h4000, 32'h8000, 32'hC000, 32'hFFFF};
    atk_rate = 16'h4000; dec_rate = 16'h6FFF; sus_level = 16'h8000; rel_rate = 16'h8000;
    do_cmd(1'b1, 60, 100, 0);
    for (int t = 0; t < 4; t++) begin
      run_tick(0);
      check_int("attack_env", obs_env[0], want[t]);
    end
    check_int("attack_addr", obs_addr[0], 480);
  endtask

  task automatic test_bend();
    do_pb(0, 20);
    run_tick(0);
    check_int("bend_addr", obs_addr[0], 484);
    check_int("decay_env", obs_env[0], 32'h9000);
    dec_rate = 16'h0000;
  endtask

  task automatic test_release();
    do_cmd(1'b0, 60, 0, 0);
    run_tick(0);
    check_int("release_env1", obs_env[0], 32'h1000);
    run_tick(0);
    check_int("release_env0", obs_env[0], 0);
    check_int("freed_voice", obs_freed, 0);
  endtask

  task automatic test_steal();
    atk_rate = 16'h0100; dec_rate = 16'h0000; sus_level = 16'h0000;
    for (int n = 0; n < 4; n++) do_cmd(1'b1, 61 + n, 10 + n, 1);
    run_tick(0);
    do_cmd(1'b1, 65, 50, 1);
    run_tick(0);
    check_int("steal0_env", obs_env[0], 32'h0100);
    check_int("steal0_vel", obs_vel[0], 50);
    check_int("steal0_phase", obs_phase[0], 260);
    check_int("steal0_other", obs_env[3], 32'h0200);
    do_cmd(1'b1, 66, 51, 1);
    run_tick(0);
    check_int("steal1_env", obs_env[1], 32'h0100);
    check_int("steal1_addr", obs_addr[1], 528);
    check_int("steal1_v0", obs_env[0], 32'h0200);
  endtask

  task automatic test_retrigger();
    atk_rate = 16'hFFFF; dec_rate = 16'h1000; sus_level = 16'h8000;
    run_tick(0);
    run_tick(0);
    check_int("pre_retrig_env", obs_env[2], 32'hEFFF);
    atk_rate = 16'h0800;
    do_cmd(1'b1, 63, 77, 1);
    run_tick(0);
    check_int("retrig_env", obs_env[2], 32'hF7FF);
    check_int("retrig_vel", obs_vel[2], 77);
    check_int("retrig_v0", obs_env[0], 32'hDFFF);
    check_int("retrig_v3", obs_env[3], 32'hDFFF);
  endtask

  task automatic test_reset_mid();
    run_tick(6);
    run_tick(0);
    check_int("post_reset_env", obs_env[2], 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_on = 1'b0; cmd_note = '0; cmd_vel = '0; cmd_chan = '0;
    pb_valid = 1'b0; pb_chan = '0; pb_value = '0;
    atk_rate = '0; dec_rate = '0; rel_rate = '0; sus_level = '0;
    model_reset();
    repeat (2) @(negedge clk96);
    test_reset();
    test_attack();
    test_bend();
    test_release();
    test_steal();
    test_retrigger();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1, "watchdog expired");
  end
endmodule
